// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one word read per cycle,
// absorbs decode stalls in a one-entry skid buffer. Optional boot loader under IMEM_LOADER_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_we_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        ld_valid_i,
  input  logic [31:0] ld_addr_i,
  input  logic [7:0]  ld_byte_i,
  output logic        ld_ready_o,
  input  logic        ld_done_i,
  output logic        ld_err_o
);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

`ifdef IMEM_LOADER_EN
  localparam state_t RST_STATE = ST_LOAD;
`else
  localparam state_t RST_STATE = ST_RUN;
`endif
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state_r;
  logic [31:0] fetch_pc_r;
  logic        inflight_v_r;
  logic [31:0] inflight_pc_r;
  logic        skid_v_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_instr_r;
  logic        issue_s;
  logic        advance_s;

`ifdef IMEM_LOADER_EN
  logic ld_acc_s;
  logic ld_in_range_s;
  logic unused_s;
  assign unused_s = ^redirect_pc_i[1:0];
`else
  logic unused_s;
  assign unused_s = ^{redirect_pc_i[1:0], ld_valid_i, ld_addr_i, ld_byte_i, ld_done_i};
`endif

  // Issue/advance decisions and loader write path; everything is gated off during reset
  always_comb begin
    issue_s   = resetn && (state_r == ST_RUN) && !redirect_i && !skid_v_r
                && !(stall_i && valid_o && inflight_v_r);
    advance_s = !valid_o || !stall_i;
    mem_re_o  = issue_s;
`ifdef IMEM_LOADER_EN
    ld_ready_o    = resetn && (state_r == ST_LOAD);
    ld_in_range_s = (ld_addr_i < MEM_LIMIT);
    ld_acc_s      = ld_valid_i && ld_ready_o;
    mem_we_o      = ld_acc_s && ld_in_range_s;
    if (mem_we_o) begin
      mem_wdata_o = ld_byte_i;
    end else begin
      mem_wdata_o = 8'h00;
    end
`else
    ld_ready_o  = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = 8'h00;
`endif
    if (issue_s) begin
      mem_addr_o = fetch_pc_r;
    end else if (mem_we_o) begin
      mem_addr_o = ld_addr_i;
    end else begin
      mem_addr_o = 32'h0000_0000;
    end
  end

  // Control state, fetch PC, in-flight tracking, skid buffer and output register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= RST_STATE;
      fetch_pc_r    <= RESET_PC;
      inflight_v_r  <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      skid_v_r      <= 1'b0;
      skid_pc_r     <= 32'h0000_0000;
      skid_instr_r  <= 32'h0000_0000;
      instr_o       <= 32'h0000_0000;
      pc_o          <= 32'h0000_0000;
      valid_o       <= 1'b0;
      ld_err_o      <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
`ifdef IMEM_LOADER_EN
          if (ld_acc_s && !ld_in_range_s) begin
            ld_err_o <= 1'b1;
          end
          if (ld_done_i) begin
            state_r    <= ST_RUN;
            fetch_pc_r <= RESET_PC;
          end
`else
          state_r <= ST_RUN;
`endif
        end
        ST_RUN: begin
          if (redirect_i) begin
            // The response landing this cycle belongs to the old stream and is dropped
            fetch_pc_r   <= {redirect_pc_i[31:2], 2'b00};
            valid_o      <= 1'b0;
            skid_v_r     <= 1'b0;
            inflight_v_r <= 1'b0;
          end else begin
            if (issue_s) begin
              fetch_pc_r    <= fetch_pc_r + 32'd4;
              inflight_v_r  <= 1'b1;
              inflight_pc_r <= fetch_pc_r;
            end else begin
              inflight_v_r <= 1'b0;
            end
            if (advance_s) begin
              if (skid_v_r) begin
                instr_o      <= skid_instr_r;
                pc_o         <= skid_pc_r;
                valid_o      <= 1'b1;
                skid_v_r     <= inflight_v_r;
                skid_instr_r <= mem_rdata_i;
                skid_pc_r    <= inflight_pc_r;
              end else if (inflight_v_r) begin
                instr_o <= mem_rdata_i;
                pc_o    <= inflight_pc_r;
                valid_o <= 1'b1;
              end else begin
                valid_o <= 1'b0;
              end
            end else if (inflight_v_r) begin
              // Issue rule keeps the skid empty whenever a response meets a stall
              skid_v_r     <= 1'b1;
              skid_instr_r <= mem_rdata_i;
              skid_pc_r    <= inflight_pc_r;
            end
          end
        end
        default: begin
          state_r <= RST_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus random stalls/redirects/resets,
// checked every cycle against a queue-based model of the fetch stream.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MEM_BYTES = 64;
`ifdef IMEM_LOADER_EN
  localparam bit LOADER = 1'b1;
`else
  localparam bit LOADER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o, pc_o;
  logic        valid_o;
  logic [31:0] mem_addr_o;
  logic        mem_re_o;
  logic [31:0] mem_rdata_i;
  logic        mem_we_o;
  logic [7:0]  mem_wdata_o;
  logic        ld_valid_i;
  logic [31:0] ld_addr_i;
  logic [7:0]  ld_byte_i;
  logic        ld_ready_o;
  logic        ld_done_i;
  logic        ld_err_o;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .resetn(resetn), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .ld_valid_i(ld_valid_i),
    .ld_addr_i(ld_addr_i), .ld_byte_i(ld_byte_i), .ld_ready_o(ld_ready_o),
    .ld_done_i(ld_done_i), .ld_err_o(ld_err_o)
  );

  // Instruction memory: loaded bytes override a fixed address-derived pattern
  logic [7:0] ld_b [0:63];
  bit         ld_w [0:63];
  int         we_cnt = 0;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (a < 32'd64 && ld_w[a[5:0]]) return ld_b[a[5:0]];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {rd_byte(a), rd_byte(a + 32'd1), rd_byte(a + 32'd2), rd_byte(a + 32'd3)};
  endfunction

  always @(posedge clk) begin
    if (mem_re_o) mem_rdata_i <= word_at(mem_addr_o);
    if (mem_we_o && mem_addr_o < 32'd64) begin
      ld_b[mem_addr_o[5:0]] <= mem_wdata_o;
      ld_w[mem_addr_o[5:0]] <= 1'b1;
    end
    if (resetn && mem_we_o) we_cnt <= we_cnt + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: ordered stream of requested words, each visible to decode from
  // two cycles after its issue until consumed; redirect and reset flush it.
  typedef struct { logic [31:0] pc; int vis; } ent_t;
  ent_t        q[$];
  logic [31:0] npc;
  bit          in_load;
  bit          err_m;
  int          t;

  task automatic model_cycle();
    int vis = 0;
    bit infl = 1'b0;
    bit exp_re, exp_ready, exp_we;
    foreach (q[i]) begin
      if (q[i].vis <= t) vis++;
      else if (q[i].vis == t + 1) infl = 1'b1;
    end
    exp_re = resetn && !in_load && !redirect_i && (vis < 2) && !(stall_i && vis >= 1 && infl);
    check_val("mem_re", 32'(mem_re_o), 32'(exp_re));
    if (exp_re) check_val("mem_addr", mem_addr_o, npc);
    check_val("valid", 32'(valid_o), 32'(vis >= 1));
    if (vis >= 1) begin
      check_val("pc", pc_o, q[0].pc);
      check_val("instr", instr_o, word_at(q[0].pc));
    end
    exp_ready = resetn && in_load;
    exp_we    = exp_ready && ld_valid_i && (ld_addr_i < 32'(MEM_BYTES));
    check_val("ld_ready", 32'(ld_ready_o), 32'(exp_ready));
    check_val("mem_we", 32'(mem_we_o), 32'(exp_we));
    check_val("ld_err", 32'(ld_err_o), 32'(err_m));
    if (exp_we) begin
      check_val("wr_addr", mem_addr_o, ld_addr_i);
      check_val("wr_data", 32'(mem_wdata_o), 32'(ld_byte_i));
    end
`ifndef IMEM_LOADER_EN
    check_val("wdata_zero", 32'(mem_wdata_o), 32'd0);
`endif
    if (!resetn) check_val("rst_comb", mem_addr_o | 32'(mem_wdata_o), 32'd0);

    if (!resetn) begin
      q.delete();
      npc     = RESET_PC;
      in_load = LOADER;
      err_m   = 1'b0;
    end else if (in_load) begin
      if (ld_valid_i && ld_addr_i >= 32'(MEM_BYTES)) err_m = 1'b1;
      if (ld_done_i) begin
        in_load = 1'b0;
        npc     = RESET_PC;
      end
    end else if (redirect_i) begin
      q.delete();
      npc = {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (vis >= 1 && !stall_i) void'(q.pop_front());
      if (exp_re) begin
        q.push_back('{pc: npc, vis: t + 2});
        npc = npc + 32'd4;
      end
    end
    t++;
  endtask

  task automatic step(input logic rn, input logic st, input logic rd, input logic [31:0] rpc);
    resetn        = rn;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sp, si;
  logic [7:0]  ld_seq [0:3];

  initial begin
    resetn = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    ld_valid_i = 1'b0; ld_addr_i = 32'd0; ld_byte_i = 8'd0; ld_done_i = 1'b0;
    q.delete(); npc = RESET_PC; in_load = LOADER; err_m = 1'b0; t = 0;
    ld_seq[0] = 8'h00; ld_seq[1] = 8'hF0; ld_seq[2] = 8'h00; ld_seq[3] = 8'h93;
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check_val("rst_valid", 32'(valid_o), 32'd0);
    check_val("rst_pc", pc_o, 32'd0);
    check_val("rst_instr", instr_o, 32'd0);
    check_val("rst_lderr", 32'(ld_err_o), 32'd0);

`ifdef IMEM_LOADER_EN
    for (int i = 0; i < 4; i++) begin
      ld_valid_i = 1'b1; ld_addr_i = 32'd4 + 32'(i); ld_byte_i = ld_seq[i];
      step(1'b1, 1'b0, 1'b0, 32'd0);
    end
    ld_addr_i = 32'd64; ld_byte_i = 8'hAA;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("ld_we_count", 32'(we_cnt), 32'd4);
    check_val("ld_err_set", 32'(ld_err_o), 32'd1);
    ld_valid_i = 1'b0; ld_done_i = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    ld_done_i = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("ld_run_valid", 32'(valid_o), 32'd1);
    check_val("ld_run_pc", pc_o, 32'd4);
    check_val("ld_run_instr", instr_o, 32'h00F0_0093);
`else
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("start_bubble", 32'(valid_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("start_valid", 32'(valid_o), 32'd1);
    check_val("start_pc0", pc_o, RESET_PC);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("start_pc1", pc_o, RESET_PC + 32'd4);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("start_pc2", pc_o, RESET_PC + 32'd8);
    check_val("start_instr2", instr_o, word_at(RESET_PC + 32'd8));
`endif
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Three-cycle stall: output frozen, then the skid entry follows with no gap
    sp = pc_o; si = instr_o;
    check_val("stall_pre_valid", 32'(valid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check_val("stall_pc_hold", pc_o, sp);
      check_val("stall_instr_hold", instr_o, si);
    end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("stall_release_pc", pc_o, sp + 32'd4);
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Redirect under stall with the skid full
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0035);
    check_val("redir_bubble1", 32'(valid_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("redir_bubble2", 32'(valid_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("redir_valid", 32'(valid_o), 32'd1);
    check_val("redir_pc", pc_o, 32'h0000_0034);
    check_val("redir_instr", instr_o, word_at(32'h0000_0034));

    // One-cycle reset in the middle of a stall with the skid full
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_val("midrst_valid", 32'(valid_o), 32'd0);
`ifdef IMEM_LOADER_EN
    ld_done_i = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    ld_done_i = 1'b0;
`endif
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("midrst_restart_valid", 32'(valid_o), 32'd1);
    check_val("midrst_restart_pc", pc_o, RESET_PC);

    // PC wrap through 2^32
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("wrap_pc0", pc_o, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("wrap_pc1", pc_o, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check_val("wrap_pc2", pc_o, 32'h0000_0000);
    check_val("wrap_instr2", instr_o, word_at(32'h0000_0000));

    // Random mix of stalls, redirects, rare resets and loader traffic
    for (int i = 0; i < 500; i++) begin
      ld_valid_i = 1'($urandom_range(0, 1));
      ld_addr_i  = 32'($urandom_range(0, 70));
      ld_byte_i  = 8'($urandom);
      ld_done_i  = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 19) == 0), 32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
